// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Definitions shared by the iterative multiplier (booth_mult) and the divider:
// the three-state controller encoding, the iteration count and the width of
// the iteration counter.
// -----------------------------------------------------------------------------
package mult_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One radix-2 step per operand bit.
   localparam int MULT_ITER = 32;

   // Counter must be able to hold MULT_ITER itself.
   localparam int CNT_W = $clog2(MULT_ITER + 1);

endpackage : mult_div_pkg

// File: rtl/booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// Combinational single radix-2 Booth iteration: conditional add/subtract of the
// multiplicand into the accumulator followed by an arithmetic right shift of
// the concatenation {acc, q, qm1}.
//
// Ports
//   m        in   WIDTH    multiplicand (two's complement)
//   acc_in   in   WIDTH+1  accumulator (sign-extended, two's complement)
//   q_in     in   WIDTH    multiplier / low product bits
//   qm1_in   in   1        bit shifted out of q on the previous step
//   acc_out  out  WIDTH+1  accumulator after add/sub and shift
//   q_out    out  WIDTH    q after shift
//   qm1_out  out  1        q_in[0]
// -----------------------------------------------------------------------------
module booth_step #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] m,
   input  logic signed [WIDTH:0]   acc_in,
   input  logic        [WIDTH-1:0] q_in,
   input  logic                    qm1_in,
   output logic signed [WIDTH:0]   acc_out,
   output logic        [WIDTH-1:0] q_out,
   output logic                    qm1_out
);

   logic signed [WIDTH:0] m_ext;
   logic signed [WIDTH:0] sum;

   assign m_ext = {m[WIDTH-1], m};

   always_comb begin
      sum = acc_in;
      case ({q_in[0], qm1_in})
         2'b01:   sum = acc_in + m_ext;
         2'b10:   sum = acc_in - m_ext;
         default: sum = acc_in;
      endcase
   end

   // Arithmetic shift right of {sum, q, qm1}: the accumulator sign bit is
   // replicated, its LSB moves into the top of q.
   assign acc_out = {sum[WIDTH], sum[WIDTH:1]};
   assign q_out   = {sum[0], q_in[WIDTH-1:1]};
   assign qm1_out = q_in[0];

endmodule : booth_step

// File: rtl/booth_mult.sv
// -----------------------------------------------------------------------------
// booth_mult
// Iterative signed 32x32 -> 64 radix-2 Booth multiplier. A start seen in IDLE
// captures a/b and runs 32 Booth steps (one per clock); the edge after the last
// step moves to DONE, registering the product into hi/lo and pulsing done for
// one cycle. hi/lo hold their value until the next completed operation.
//
// Ports
//   clk    in   1      clock, rising edge
//   reset  in   1      asynchronous active-low reset
//   start  in   1      launch request, honoured only in IDLE
//   a      in   WIDTH  multiplicand, signed, sampled with start
//   b      in   WIDTH  multiplier, signed, sampled with start
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle pulse, hi/lo newly valid
//   hi     out  WIDTH  upper half of signed product
//   lo     out  WIDTH  lower half of signed product
// -----------------------------------------------------------------------------
module booth_mult
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t                  state;
   logic signed [WIDTH-1:0] m;
   logic signed [WIDTH:0]   acc;    // one guard bit so -2^31 * -2^31 cannot overflow
   logic        [WIDTH-1:0] q;
   logic                    qm1;
   logic        [CNT_W-1:0] count;

   logic signed [WIDTH:0]   acc_nx;
   logic        [WIDTH-1:0] q_nx;
   logic                    qm1_nx;

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .m       (m),
      .acc_in  (acc),
      .q_in    (q),
      .qm1_in  (qm1),
      .acc_out (acc_nx),
      .q_out   (q_nx),
      .qm1_out (qm1_nx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         m     <= '0;
         acc   <= '0;
         q     <= '0;
         qm1   <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m     <= a;
                  q     <= b;
                  qm1   <= 1'b0;
                  acc   <= '0;
                  count <= CNT_W'(MULT_ITER);
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // All 32 steps are done once count has reached zero; this edge
               // only publishes the result, so start here is simply ignored.
               if (count == '0) begin
                  hi    <= acc[WIDTH-1:0];
                  lo    <= q;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  acc   <= acc_nx;
                  q     <= q_nx;
                  qm1   <= qm1_nx;
                  count <= count - CNT_W'(1);
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : booth_mult

// File: tb/tb_booth_mult.sv
module tb_booth_mult;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk;
   int n_err;

   // Product of the last completed operation, as the model sees it.
   logic [63:0] last_prod;

   booth_mult #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return 64'(p);
   endfunction

   // Called at a falling edge. Launches a multiply, scrambles a/b while it
   // runs, optionally re-pulses start at edge repulse_at, and returns at the
   // falling edge where done is seen (or after a bounded wait).
   task automatic do_mult(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input int repulse_at);
      int          edges;
      logic        busy_ok;
      logic [63:0] exp;
      exp   = ref_prod(ia, ib);
      a     = ia;
      b     = ib;
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      edges   = 0;
      busy_ok = 1'b1;
      while (!done && edges < 40) begin
         if (!busy) busy_ok = 1'b0;
         if (edges == 1 || edges == 32)
            check({tag, "_hold"}, {hi, lo}, last_prod);
         a     = $urandom;
         b     = $urandom;
         start = (edges == repulse_at);
         @(negedge clk);
         start = 1'b0;
         edges++;
      end
      check({tag, "_busy"}, 64'(busy_ok && busy), 64'd1);
      check({tag, "_lat"}, 64'(edges), 64'd33);
      check({tag, "_prod"}, {hi, lo}, exp);
      last_prod = exp;
   endtask

   // From the done cycle: the next cycle must be idle with done low.
   task automatic expect_idle(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      last_prod = '0;
      reset     = 1'b0;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      check("rst_state", {28'd0, busy, done, 2'b00, hi, lo} >> 0, 64'd0);
      check("rst_outs", {busy, done, hi, lo}, {30'd0, 34'd0});
      reset = 1'b1;
      @(negedge clk);

      do_mult("d7x6", 32'd7, 32'd6, -1);
      expect_idle("d7x6");
      do_mult("dneg3x5", 32'hFFFF_FFFD, 32'd5, -1);
      expect_idle("dneg3x5");
      do_mult("dminxmin", 32'h8000_0000, 32'h8000_0000, -1);
      expect_idle("dminxmin");
      do_mult("dmaxrep", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 10);
      expect_idle("dmaxrep");

      // Abort mid-run with reset.
      a     = 32'd1234567;
      b     = 32'd7654321;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hilo", {hi, lo}, 64'd0);
      check("abort_done", 64'(done), 64'd0);
      last_prod = '0;
      begin
         logic seen;
         seen = 1'b0;
         repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (reset == 1'b0) reset = 1'b1;
         end
         check("abort_nodone", 64'(seen), 64'd0);
      end
      do_mult("d2xneg1", 32'd2, 32'hFFFF_FFFF, -1);
      expect_idle("d2xneg1");

      // Start in the DONE cycle is ignored; one cycle later is accepted.
      do_mult("b2b_first", 32'd1000, 32'hFFFF_FF00, -1);
      a     = 32'd99;
      b     = 32'd99;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_ignored", 64'(busy), 64'd0);
      check("b2b_nodone", 64'(done), 64'd0);
      do_mult("b2b_second", 32'h1234_5678, 32'h9ABC_DEF0, -1);
      expect_idle("b2b_second");

      for (int i = 0; i < 8; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (i == 0) ra = 32'h8000_0000;
         if (i == 1) rb = 32'd0;
         do_mult("rand", ra, rb, (i % 3 == 0) ? 5 + i : -1);
         expect_idle("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_booth_mult
